// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, oversampling constants,
// vote sample positions and the frame FSM state type.
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   localparam int OVERSAMPLE = 16;

   // Three votes straddle the bit centre; the bit closes on the last sample.
   localparam logic [3:0] VOTE_S0  = 4'd7;
   localparam logic [3:0] VOTE_S1  = 4'd8;
   localparam logic [3:0] VOTE_S2  = 4'd9;
   localparam logic [3:0] BIT_LAST = 4'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PAR,
      ST_STOP
   } uart_state_t;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running oversample tick generator: one tick every baud_div+1 clocks.
// A new divisor is picked up at the next reload, so the tick phase never jumps.
module uart_baud_gen #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [DIV_W-1:0] baud_div,
   output logic             tick
);

   logic [DIV_W-1:0] cnt;

   assign tick = (cnt == '0);

   // Down-counter, reloaded with the divisor in the tick cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    cnt <= '0;
      else if (tick) cnt <= baud_div;
      else           cnt <= cnt - DIV_W'(1);
   end

endmodule

// File: rtl/uart_rx_os.sv
// 16x oversampled UART receiver with 3-sample majority vote, compile-time
// frame format and a valid/ready holding register with error flags.
module uart_rx_os
   import uart_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1,
   parameter int DIV_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DIV_W-1:0]     baud_div,
   input  logic                 rx_serial,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun
);

   localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);

   uart_state_t          state, state_nxt;
   logic [1:0]           sync;
   logic                 rx_s;
   logic                 tick;
   logic [3:0]           s;
   logic                 v0, v1;
   logic                 vote, at_vote, at_end, last_stop, done;
   logic [DATA_BITS-1:0] shreg;
   logic [3:0]           bit_cnt;
   logic                 stop_cnt;
   logic                 frm_acc, par_acc, exp_par;

   uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
      .clk      (clk),
      .rst_n    (rst_n),
      .baud_div (baud_div),
      .tick     (tick)
   );

   // Two-flop synchroniser, idle-high reset so no false start out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync <= 2'b11;
      else        sync <= {sync[0], rx_serial};
   end

   assign rx_s      = sync[1];
   assign vote      = maj3(v0, v1, rx_s);
   assign at_vote   = tick && (s == VOTE_S2);
   assign at_end    = tick && (s == BIT_LAST);
   assign last_stop = (STOP_BITS == 1) || stop_cnt;
   assign exp_par   = (PARITY == PAR_ODD) ? ~(^shreg) : ^shreg;

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode; the frame completes on the last stop-bit vote so a
   // following start edge is caught without waiting out the stop bit.
   always_comb begin
      state_nxt = state;
      done      = 1'b0;
      case (state)
         ST_IDLE:  if (tick && !rx_s) state_nxt = ST_START;
         ST_START: begin
            if (at_vote && vote) state_nxt = ST_IDLE;
            else if (at_end)     state_nxt = ST_DATA;
         end
         ST_DATA:  if (at_end && bit_cnt == LAST_DATA)
                      state_nxt = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
         ST_PAR:   if (at_end) state_nxt = ST_STOP;
         ST_STOP:  if (at_vote && last_stop) begin
                      done      = 1'b1;
                      state_nxt = ST_IDLE;
                   end
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Sample counter, vote capture, shift register and per-frame error accumulation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s        <= '0;
         v0       <= 1'b1;
         v1       <= 1'b1;
         shreg    <= '0;
         bit_cnt  <= '0;
         stop_cnt <= 1'b0;
         frm_acc  <= 1'b0;
         par_acc  <= 1'b0;
      end else begin
         if (state == ST_IDLE) s <= '0;
         else if (tick)        s <= s + 4'd1;
         if (tick && s == VOTE_S0) v0 <= rx_s;
         if (tick && s == VOTE_S1) v1 <= rx_s;
         case (state)
            ST_IDLE: begin
               bit_cnt  <= '0;
               stop_cnt <= 1'b0;
               frm_acc  <= 1'b0;
               par_acc  <= 1'b0;
            end
            ST_DATA: begin
               if (at_vote) shreg   <= {vote, shreg[DATA_BITS-1:1]};
               if (at_end)  bit_cnt <= bit_cnt + 4'd1;
            end
            ST_PAR:  if (at_vote) par_acc <= vote ^ exp_par;
            ST_STOP: begin
               if (at_vote) frm_acc  <= frm_acc | ~vote;
               if (at_end)  stop_cnt <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Holding register: load when empty or being drained, otherwise drop and flag overrun.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         overrun <= done && rx_valid && !rx_ready;
         if (done && (!rx_valid || rx_ready)) begin
            rx_data    <= shreg;
            rx_valid   <= 1'b1;
            frame_err  <= frm_acc | ~vote;
            parity_err <= par_acc;
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: an 8N1 and an 8E2 instance driven with directed and
// random frames; a scoreboard of expected frames is checked every cycle.
module tb_uart_rx_os;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] baud_div;
   logic        a_ser, b_ser;
   logic [7:0]  a_data, b_data;
   logic        a_valid, b_valid, a_fe, b_fe, a_pe, b_pe, a_ovr, b_ovr;
   logic        a_rdy, b_rdy, a_mrdy, b_mrdy, rnd_a, rnd_b, rnd_en;

   typedef struct {
      logic [7:0] d;
      logic       fe;
      logic       pe;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   int   checks = 0, errors = 0;
   int   ovr_a = 0, ovr_b = 0, got_a = 0, got_b = 0, sent_a = 0, sent_b = 0;

   always #5 clk = ~clk;

   assign a_rdy = rnd_en ? rnd_a : a_mrdy;
   assign b_rdy = rnd_en ? rnd_b : b_mrdy;

   uart_rx_os #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DIV_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .rx_serial(a_ser),
      .rx_data(a_data), .rx_valid(a_valid), .rx_ready(a_rdy),
      .frame_err(a_fe), .parity_err(a_pe), .overrun(a_ovr));

   uart_rx_os #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .DIV_W(16)) dut_b (
      .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .rx_serial(b_ser),
      .rx_data(b_data), .rx_valid(b_valid), .rx_ready(b_rdy),
      .frame_err(b_fe), .parity_err(b_pe), .overrun(b_ovr));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected frame from the line-level view: even parity means data plus
   // parity bit carry an even number of ones; any low stop bit is a frame error.
   function automatic exp_t model(input bit is_b, input logic [7:0] d,
                                  input logic pbit, input logic [1:0] stops);
      exp_t e;
      int   ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      e.d  = d;
      e.pe = is_b ? (((ones + int'(pbit)) % 2) != 0) : 1'b0;
      e.fe = is_b ? !(stops[0] && stops[1]) : !stops[0];
      return e;
   endfunction

   // Drive one frame; caller is aligned to posedge+1. rad raises ready in the
   // completion cycle (valid for baud_div = 0 only). push queues the expectation.
   task automatic send(input bit to_b, input logic [7:0] d, input logic pbit,
                       input logic [1:0] stops, input bit rad, input bit push);
      logic [15:0] bits;
      int          len, per;
      bits     = '1;
      bits[0]  = 1'b0;
      bits[8:1] = d;
      if (to_b) begin
         bits[9] = pbit; bits[10] = stops[0]; bits[11] = stops[1]; len = 12;
      end else begin
         bits[9] = stops[0]; len = 10;
      end
      if (push) begin
         if (to_b) begin qb.push_back(model(1'b1, d, pbit, stops)); sent_b++; end
         else      begin qa.push_back(model(1'b0, d, pbit, stops)); sent_a++; end
      end
      per = 16 * (int'(baud_div) + 1);
      for (int i = 0; i < len; i++) begin
         if (to_b) b_ser = bits[i]; else a_ser = bits[i];
         if (rad && i == len - 1) begin
            repeat (12) @(posedge clk);
            #1;
            if (to_b) b_mrdy = 1'b1; else a_mrdy = 1'b1;
            repeat (per - 12) @(posedge clk);
            #1;
         end else begin
            repeat (per) @(posedge clk);
            #1;
         end
      end
      a_ser = 1'b1;
      b_ser = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic accept(input bit to_b);
      if (to_b) b_mrdy = 1'b1; else a_mrdy = 1'b1;
      idle(2);
      if (to_b) b_mrdy = 1'b0; else a_mrdy = 1'b0;
   endtask

   // Random ready for the random phase.
   initial begin
      rnd_a = 1'b0;
      rnd_b = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         rnd_a = 1'($urandom_range(0, 1));
         rnd_b = 1'($urandom_range(0, 1));
      end
   end

   // Scoreboard compare on every falling edge while out of reset.
   always @(negedge clk) begin
      if (rst_n) begin
         if (a_ovr) ovr_a++;
         if (b_ovr) ovr_b++;
         if (a_valid) begin
            if (qa.size() == 0) begin
               checks++; errors++;
               $display("FAIL a_unexpected_valid: got data %0h with nothing expected", a_data);
            end else begin
               chk("a_data", 32'(a_data), 32'(qa[0].d));
               chk("a_frame_err", 32'(a_fe), 32'(qa[0].fe));
               chk("a_parity_err", 32'(a_pe), 32'(qa[0].pe));
               if (a_rdy) begin qa.delete(0); got_a++; end
            end
         end
         if (b_valid) begin
            if (qb.size() == 0) begin
               checks++; errors++;
               $display("FAIL b_unexpected_valid: got data %0h with nothing expected", b_data);
            end else begin
               chk("b_data", 32'(b_data), 32'(qb[0].d));
               chk("b_frame_err", 32'(b_fe), 32'(qb[0].fe));
               chk("b_parity_err", 32'(b_pe), 32'(qb[0].pe));
               if (b_rdy) begin qb.delete(0); got_b++; end
            end
         end
      end
   end

   initial begin
      int          per, gap;
      logic [7:0]  d;
      logic [1:0]  st;
      logic        pb;
      rst_n    = 1'b0;
      baud_div = '0;
      a_ser    = 1'b1;
      b_ser    = 1'b1;
      a_mrdy   = 1'b0;
      b_mrdy   = 1'b0;
      rnd_en   = 1'b0;
      idle(3);
      chk("rst_valid", 32'(a_valid | b_valid), 0);
      chk("rst_data", 32'({a_data, b_data}), 0);
      chk("rst_flags", 32'({a_fe, a_pe, b_fe, b_pe, a_ovr, b_ovr}), 0);
      rst_n = 1'b1;
      idle(5);

      // 8N1 0xA5: held until ready, flags clear.
      send(1'b0, 8'hA5, 1'b0, 2'b11, 1'b0, 1'b1);
      idle(40);
      chk("a5_valid_held", 32'(a_valid), 1);
      chk("a5_data", 32'(a_data), 32'h A5);
      chk("a5_flags", 32'({a_fe, a_pe}), 0);
      accept(1'b0);
      chk("a5_valid_clear", 32'(a_valid), 0);

      // 8E2: 0x03 with parity bit 1 is a parity error, with 0 it is not.
      send(1'b1, 8'h03, 1'b1, 2'b11, 1'b0, 1'b1);
      idle(20);
      chk("par1_valid", 32'(b_valid), 1);
      chk("par1_err", 32'(b_pe), 1);
      chk("par1_data", 32'(b_data), 32'h03);
      accept(1'b1);
      send(1'b1, 8'h03, 1'b0, 2'b11, 1'b0, 1'b1);
      idle(20);
      chk("par0_err", 32'(b_pe), 0);
      chk("par0_data", 32'(b_data), 32'h03);
      accept(1'b1);

      // Second stop bit low: frame error, data still delivered.
      send(1'b1, 8'h5C, 1'b0, 2'b01, 1'b0, 1'b1);
      idle(20);
      chk("ferr_valid", 32'(b_valid), 1);
      chk("ferr_flag", 32'(b_fe), 1);
      chk("ferr_data", 32'(b_data), 32'h5C);
      accept(1'b1);
      idle(40);

      // 3-tick glitch is rejected and the receiver still takes the next frame.
      a_ser = 1'b0;
      idle(3);
      a_ser = 1'b1;
      idle(40);
      chk("glitch_no_valid", 32'(a_valid), 0);
      send(1'b0, 8'h3C, 1'b0, 2'b11, 1'b0, 1'b1);
      idle(10);
      chk("post_glitch_data", 32'(a_data), 32'h3C);
      accept(1'b0);
      chk("glitch_got", 32'(got_a), 2);

      // Back-to-back with no acceptance: second frame dropped, one overrun.
      send(1'b0, 8'h11, 1'b0, 2'b11, 1'b0, 1'b1);
      send(1'b0, 8'h22, 1'b0, 2'b11, 1'b0, 1'b0);
      idle(10);
      chk("ovr_data_kept", 32'(a_data), 32'h11);
      chk("ovr_count", 32'(ovr_a), 1);
      accept(1'b0);
      // Ready in the completion cycle: second frame loads, no overrun.
      send(1'b0, 8'h11, 1'b0, 2'b11, 1'b0, 1'b1);
      send(1'b0, 8'h22, 1'b0, 2'b11, 1'b1, 1'b1);
      idle(10);
      a_mrdy = 1'b0;
      chk("no_ovr_count", 32'(ovr_a), 1);
      chk("no_ovr_got", 32'(got_a), 5);

      // Reset mid-DATA with a frame already held: everything is discarded.
      send(1'b0, 8'h77, 1'b0, 2'b11, 1'b0, 1'b1);
      a_ser = 1'b0; idle(16);
      a_ser = 1'b1; idle(16);
      a_ser = 1'b0; idle(16);
      a_ser = 1'b1; idle(8);
      rst_n = 1'b0;
      qa.delete();
      idle(3);
      chk("midrst_valid", 32'(a_valid), 0);
      chk("midrst_data", 32'(a_data), 0);
      a_ser = 1'b1;
      rst_n = 1'b1;
      idle(40);
      chk("postrst_idle", 32'(a_valid), 0);
      send(1'b0, 8'h5A, 1'b0, 2'b11, 1'b0, 1'b1);
      idle(10);
      chk("postrst_valid", 32'(a_valid), 1);
      chk("postrst_data", 32'(a_data), 32'h5A);
      chk("postrst_flags", 32'({a_fe, a_pe}), 0);
      accept(1'b0);
      got_a  = 0; sent_a = 0;
      got_b  = 0; sent_b = 0;

      // Random frames, divisors, error injection and consumer back-pressure.
      rnd_en = 1'b1;
      for (int b = 0; b < 3; b++) begin
         baud_div = 16'($urandom_range(0, 2));
         per = 16 * (int'(baud_div) + 1);
         idle(2 * per);
         for (int f = 0; f < 16; f++) begin
            d  = 8'($urandom);
            st = 2'b11;
            if ($urandom_range(0, 4) == 0) st[0] = 1'b0;
            if ($urandom_range(0, 4) == 0) st[1] = 1'b0;
            pb = (^d) ^ ($urandom_range(0, 3) == 0);
            send(f[0], d, pb, st, 1'b0, 1'b1);
            if (!(st[0] && (st[1] || !f[0]))) gap = per + $urandom_range(0, per);
            else                               gap = $urandom_range(0, per);
            if (gap > 0) idle(gap);
         end
      end
      idle(200);
      rnd_en = 1'b0;
      chk("rnd_a_pending", 32'(qa.size()), 0);
      chk("rnd_b_pending", 32'(qb.size()), 0);
      chk("rnd_a_got", 32'(got_a), 32'(sent_a));
      chk("rnd_b_got", 32'(got_b), 32'(sent_b));
      chk("final_ovr_a", 32'(ovr_a), 1);
      chk("final_ovr_b", 32'(ovr_b), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
